// File: rtl/map_switch_ctrl_pkg.sv
// Shared mapper-hub definitions: select codes, mapper index constants, switch FSM encoding.
// Combinational only; no latency and no flow control.
package map_switch_ctrl_pkg;

    localparam logic [1:0] SEL_NOM = 2'd0;
    localparam logic [1:0] SEL_261 = 2'd1;
    localparam logic [1:0] SEL_389 = 2'd2;

    localparam int unsigned MAP_IDX_261 = 261;
    localparam int unsigned MAP_IDX_389 = 389;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Q = 2'd1,
        RST    = 2'd2,
        REL    = 2'd3
    } state_t;

endpackage

// File: rtl/map_switch_ctrl_quiet_det.sv
// Consecutive quiet-cycle detector: ok fires on the IDLE_CYC-th consecutive quiet cycle.
// Latency: ok includes the current cycle's quiet input; no backpressure, count clears when en=0.
module quiet_det #(
    parameter int IDLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic quiet,
    output logic ok
);

    localparam int CW = $clog2(IDLE_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && quiet) begin
            cnt_d = (cnt_q == CW'(IDLE_CYC)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign ok = en && quiet && (cnt_d == CW'(IDLE_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/map_switch_ctrl.sv
// Sequences mapper switches: wait for quiet bus, hold map_rst RST_CYC cycles, pulse done.
// Latency: done IDLE_CYC+RST_CYC+1 cycles after accept (1 if index unchanged); req_ready only in IDLE, busy requests dropped.
module map_switch_ctrl
    import map_switch_ctrl_pkg::*;
#(
    parameter int IDX_W    = 10,
    parameter int IDLE_CYC = 4,
    parameter int RST_CYC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    input  logic             cpu_m2,
    input  logic             ss_act,
    output logic [1:0]       map_sel,
    output logic [IDX_W-1:0] cur_idx,
    output logic             map_rst,
    output logic             busy,
    output logic             done
);

    localparam int RCW = $clog2(RST_CYC + 1);
    localparam int XW  = (IDX_W > 32) ? IDX_W : 32;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [1:0]       map_sel_q, map_sel_d;
    logic             map_rst_q, map_rst_d;
    logic             done_q, done_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             quiet_ok;
    logic [XW-1:0]    pend_x;
    logic [1:0]       pend_sel;

    quiet_det #(
        .IDLE_CYC (IDLE_CYC)
    ) u_quiet_det (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == WAIT_Q),
        .quiet (!cpu_m2 && !ss_act),
        .ok    (quiet_ok)
    );

    // Compare at >=32 bits so narrow IDX_W can never alias onto 261/389.
    assign pend_x = XW'(pend_idx_q);

    always_comb begin
        pend_sel = SEL_NOM;
        if (pend_x == XW'(MAP_IDX_261)) begin
            pend_sel = SEL_261;
        end else if (pend_x == XW'(MAP_IDX_389)) begin
            pend_sel = SEL_389;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_idx_d = pend_idx_q;
        cur_idx_d  = cur_idx_q;
        map_sel_d  = map_sel_q;
        map_rst_d  = map_rst_q;
        rcnt_d     = rcnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pend_idx_d = req_idx;
                    if (req_idx == cur_idx_q) begin
                        state_d = REL;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_Q;
                    end
                end
            end
            WAIT_Q: begin
                if (quiet_ok) begin
                    state_d   = RST;
                    map_sel_d = pend_sel;
                    cur_idx_d = pend_idx_q;
                    map_rst_d = 1'b1;
                    rcnt_d    = RCW'(1);
                end
            end
            RST: begin
                if (rcnt_q == RCW'(RST_CYC)) begin
                    state_d   = REL;
                    map_rst_d = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_idx_q <= '0;
            cur_idx_q  <= '0;
            map_sel_q  <= SEL_NOM;
            map_rst_q  <= 1'b0;
            done_q     <= 1'b0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_idx_q <= pend_idx_d;
            cur_idx_q  <= cur_idx_d;
            map_sel_q  <= map_sel_d;
            map_rst_q  <= map_rst_d;
            done_q     <= done_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign map_sel   = map_sel_q;
    assign cur_idx   = cur_idx_q;
    assign map_rst   = map_rst_q;
    assign done      = done_q;

endmodule

// File: tb/tb_map_switch_ctrl.sv
// Scenario bench for map_switch_ctrl: completions are checked against a queue of expected switches.
module tb_map_switch_ctrl;

    localparam int IDX_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [IDX_W-1:0] req_idx = '0;
    logic             cpu_m2 = 1'b0;
    logic             ss_act = 1'b0;
    logic             req_ready;
    logic [1:0]       map_sel;
    logic [IDX_W-1:0] cur_idx;
    logic             map_rst;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]       sel;
        logic [IDX_W-1:0] idx;
        int               dcyc;
    } exp_t;
    exp_t sb[$];

    map_switch_ctrl #(.IDX_W(IDX_W), .IDLE_CYC(4), .RST_CYC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .cpu_m2    (cpu_m2),
        .ss_act    (ss_act),
        .map_sel   (map_sel),
        .cur_idx   (cur_idx),
        .map_rst   (map_rst),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one accept cycle T; returns with the bench at the negedge of cycle T+1.
    task automatic accept(input logic [IDX_W-1:0] idx, output int t1);
        req_valid = 1'b1;
        req_idx   = idx;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL accept_ready idx=%0d: got %b want 1", idx, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        t1 = cyc;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fails++;
            $display("FAIL %s_unexpected_done: got done with empty scoreboard, want none", name);
        end else begin
            e = sb.pop_front();
            n_checks += 2;
            if (map_sel !== e.sel || cur_idx !== e.idx) begin
                n_fails++;
                $display("FAIL %s_done_data: got sel=%0d idx=%0d want sel=%0d idx=%0d",
                         name, map_sel, cur_idx, e.sel, e.idx);
            end
            if (cyc !== e.dcyc) begin
                n_fails++;
                $display("FAIL %s_done_cycle: got %0d want %0d", name, cyc, e.dcyc);
            end
        end
    endtask

    // rs = cycle offset where map_rst first rises; m2_k/noise_k = offsets where cpu_m2 pulses.
    task automatic run_switch(input string name, input logic [IDX_W-1:0] idx,
                              input logic [1:0] sel, input logic [1:0] prev_sel,
                              input int m2_k, input int noise_k, input int ss_end, input int rs);
        int t1;
        int dk;
        dk = rs + 8;
        ss_act = (ss_end > 0);
        accept(idx, t1);
        sb.push_back('{sel, idx, t1 + dk - 1});
        for (int k = 1; k <= dk + 1; k++) begin
            cpu_m2 = (k == m2_k) || (k == noise_k);
            ss_act = (k <= ss_end);
            n_checks += 4;
            if (map_rst !== (k >= rs && k < dk)) begin
                n_fails++;
                $display("FAIL %s_map_rst k=%0d: got %b want %b", name, k, map_rst, (k >= rs && k < dk));
            end
            if (done !== (k == dk)) begin
                n_fails++;
                $display("FAIL %s_done k=%0d: got %b want %b", name, k, done, (k == dk));
            end
            if (busy !== (k <= dk)) begin
                n_fails++;
                $display("FAIL %s_busy k=%0d: got %b want %b", name, k, busy, (k <= dk));
            end
            if (map_sel !== ((k >= rs) ? sel : prev_sel)) begin
                n_fails++;
                $display("FAIL %s_map_sel k=%0d: got %0d want %0d", name, k, map_sel,
                         (k >= rs) ? sel : prev_sel);
            end
            if (done === 1'b1) pop_check(name);
            @(negedge clk);
        end
        cpu_m2 = 1'b0;
        ss_act = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL %s_missing_done: got %0d pending want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks += 2;
        if (map_sel !== 2'd0 || cur_idx !== '0 || map_rst !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_outputs: got sel=%0d idx=%0d rst=%b want 0 0 0", map_sel, cur_idx, map_rst);
        end
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_flags: got done=%b busy=%b want 0 0", done, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        if (map_sel !== 2'd0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: got sel=%0d busy=%b want 0 0", map_sel, busy);
        end
    endtask

    task automatic test_sel_261();
        run_switch("sel261", 10'd261, 2'd1, 2'd0, 0, 0, 0, 5);
    endtask

    task automatic test_m2_restart();
        run_switch("m2restart", 10'd389, 2'd2, 2'd1, 3, 10, 0, 8);
    endtask

    task automatic test_ss_hold();
        run_switch("sshold", 10'd261, 2'd1, 2'd2, 0, 28, 20, 25);
    endtask

    task automatic test_same_idx();
        int t1;
        accept(10'd261, t1);
        sb.push_back('{2'd1, 10'd261, t1});
        req_valid = 1'b1;
        req_idx   = 10'd389;
        n_checks += 3;
        if (req_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL same_busy_ready: got %b want 0", req_ready);
        end
        if (done !== 1'b1) begin
            n_fails++;
            $display("FAIL same_done: got %b want 1", done);
        end
        if (map_rst !== 1'b0) begin
            n_fails++;
            $display("FAIL same_map_rst: got %b want 0", map_rst);
        end
        if (done === 1'b1) pop_check("same");
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            n_checks += 2;
            if (map_rst !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fails++;
                $display("FAIL same_after k=%0d: got rst=%b done=%b busy=%b want 0 0 0", k, map_rst, done, busy);
            end
            if (cur_idx !== 10'd261 || map_sel !== 2'd1) begin
                n_fails++;
                $display("FAIL same_dropped k=%0d: got idx=%0d sel=%0d want 261 1", k, cur_idx, map_sel);
            end
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL same_missing_done: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        int t1;
        accept(10'd5, t1);
        for (int k = 1; k <= 7; k++) begin
            n_checks += 2;
            if (map_sel !== ((k >= 5) ? 2'd0 : 2'd1)) begin
                n_fails++;
                $display("FAIL idx5_map_sel k=%0d: got %0d want %0d", k, map_sel, (k >= 5) ? 0 : 1);
            end
            if (map_rst !== (k >= 5)) begin
                n_fails++;
                $display("FAIL idx5_map_rst k=%0d: got %b want %b", k, map_rst, (k >= 5));
            end
            if (k < 7) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (map_rst !== 1'b0 || map_sel !== 2'd0) begin
            n_fails++;
            $display("FAIL arst_outputs: got rst=%b sel=%0d want 0 0", map_rst, map_sel);
        end
        if (cur_idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fails++;
            $display("FAIL arst_state: got idx=%0d busy=%b done=%b want 0 0 0", cur_idx, busy, done);
        end
        if (req_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL arst_ready: got %b want 1", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || map_rst !== 1'b0) begin
                n_fails++;
                $display("FAIL arst_after k=%0d: got done=%b busy=%b rst=%b want 0 0 0", k, done, busy, map_rst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel_261();
        test_m2_restart();
        test_ss_hold();
        test_same_idx();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
